// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared BTB constants and 2-bit saturating counter helpers
package branch_predict_unit_pkg;
   localparam logic [1:0] BTB_CNT_WT = 2'b10;
   function automatic logic [1:0] sat2_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction
   function automatic logic [1:0] sat2_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch predict port, EX resolve port, redirect and statistics
interface branch_predict_unit_if #(parameter int XLEN = 64);
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic            ex_is_jump;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     branch_cnt;
   logic [31:0]     mispred_cnt;
   modport master (
      output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, redirect_valid, redirect_pc, branch_cnt, mispred_cnt
   );
   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, redirect_valid, redirect_pc, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_predict_unit_btb_table.sv
// branch_predict_unit_btb_table: direct-mapped BTB storage, async read port and training write port
module branch_predict_unit_btb_table
   import branch_predict_unit_pkg::*;
#(
   parameter int         XLEN     = 64,
   parameter int         ENTRIES  = 64,
   parameter int         TAG_W    = 10,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output logic                       rd_valid,
   output logic [TAG_W-1:0]           rd_tag,
   output logic                       rd_jump,
   output logic [1:0]                 rd_cnt,
   output logic [XLEN-1:0]            rd_target,
   input  logic                       wr_en,
   input  logic [$clog2(ENTRIES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]           wr_tag,
   input  logic                       wr_jump,
   input  logic                       wr_taken,
   input  logic [XLEN-1:0]            wr_target
);
   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] jump;
   logic [1:0]         cnt [ENTRIES];
   logic [TAG_W-1:0]   tag [ENTRIES];
   logic [XLEN-1:0]    target [ENTRIES];
   logic               wr_hit;
   assign rd_valid  = valid[rd_idx];
   assign rd_tag    = tag[rd_idx];
   assign rd_jump   = jump[rd_idx];
   assign rd_cnt    = cnt[rd_idx];
   assign rd_target = target[rd_idx];
   assign wr_hit    = valid[wr_idx] && tag[wr_idx] == wr_tag;
   // hits train in place; taken misses allocate with a weakly-taken counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_INIT;
      end else if (wr_en && (wr_hit || wr_taken)) begin
         valid[wr_idx] <= 1'b1;
         cnt[wr_idx]   <= !wr_hit ? BTB_CNT_WT : wr_jump ? cnt[wr_idx] :
                          wr_taken ? sat2_inc(cnt[wr_idx]) : sat2_dec(cnt[wr_idx]);
      end
   always_ff @(posedge clk)
      if (wr_en && wr_taken) begin
         target[wr_idx] <= wr_target;
         if (!wr_hit) begin
            tag[wr_idx]  <= wr_tag;
            jump[wr_idx] <= wr_jump;
         end
      end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB next-PC predictor with EX-stage resolve, registered redirect and stats
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int         XLEN     = 64,
   parameter int         ENTRIES  = 64,
   parameter int         TAG_W    = 10,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic                  clk,
   input logic                  reset,
   branch_predict_unit_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             is_jump;
      logic [1:0]       cnt;
      logic [XLEN-1:0]  target;
   } btb_entry_t;
   btb_entry_t       rd;
   logic             rd_valid, rd_jump;
   logic [TAG_W-1:0] rd_tag;
   logic [1:0]       rd_cnt;
   logic [XLEN-1:0]  rd_target;
   logic             hit, pred_taken, accept, mispredict, redirect_valid;
   logic [XLEN-1:0]  actual_next, redirect_pc;
   logic [31:0]      bcnt, mcnt;
   branch_predict_unit_btb_table #(
      .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_INIT(CNT_INIT)
   ) u_table (
      .clk(clk),
      .reset(reset),
      .rd_idx(bus.if_pc[IDX_W+1:2]),
      .rd_valid(rd_valid),
      .rd_tag(rd_tag),
      .rd_jump(rd_jump),
      .rd_cnt(rd_cnt),
      .rd_target(rd_target),
      .wr_en(accept),
      .wr_idx(bus.ex_pc[IDX_W+1:2]),
      .wr_tag(bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2]),
      .wr_jump(bus.ex_is_jump),
      .wr_taken(bus.ex_taken),
      .wr_target(bus.ex_target)
   );
   assign rd              = {rd_valid, rd_tag, rd_jump, rd_cnt, rd_target};
   assign hit             = rd.valid && rd.tag == bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign pred_taken      = hit && (rd.is_jump || rd.cnt[1]);
   assign bus.pred_taken  = pred_taken;
   assign bus.pred_target = pred_taken ? rd.target : bus.if_pc + XLEN'(4);
   // the slot right after a redirect carries a wrong-path instruction
   assign accept      = bus.ex_valid && !redirect_valid;
   assign actual_next = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
   assign mispredict  = (bus.ex_pred_taken != bus.ex_taken) ||
                        (bus.ex_taken && bus.ex_pred_target != bus.ex_target);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         bcnt           <= '0;
         mcnt           <= '0;
      end else begin
         redirect_valid <= accept && mispredict;
         if (accept && mispredict) redirect_pc <= actual_next;
         if (accept) bcnt <= bcnt + 32'd1;
         if (accept && mispredict) mcnt <= mcnt + 32'd1;
      end
   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = redirect_pc;
   assign bus.branch_cnt     = bcnt;
   assign bus.mispred_cnt    = mcnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vector table, randomized resolves vs a behavioural BTB model,
// and reset/wrap corner sequences on a 4-entry instance
module tb_branch_predict_unit;
   localparam int XLEN = 64, ENTRIES = 4, TAG_W = 10;
   logic clk = 1'b0, reset = 1'b0;
   always #5 clk = ~clk;
   branch_predict_unit_if #(.XLEN(XLEN)) bus ();
   branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_INIT(2'b01))
      dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [63:0] if_pc;
      bit          ev;
      logic [63:0] ex_pc;
      bit          jmp, tk;
      logic [63:0] tgt;
      bit          ptk;
      logic [63:0] ptgt;
      bit          e_pt;
      logic [63:0] e_ptgt;
      bit          e_rv;
      logic [63:0] e_rpc;
      int          e_bc, e_mc;
   } vec_t;

   int total = 0, bad = 0;
   bit          m_valid [ENTRIES];
   int          m_tag [ENTRIES];
   bit          m_jump [ENTRIES];
   int          m_cnt [ENTRIES];
   logic [63:0] m_tgt [ENTRIES];
   bit          m_rv;
   logic [63:0] m_rpc;
   logic [31:0] m_bc, m_mc;
   vec_t        tv [16];

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc / 64'd4) % 64'(ENTRIES));
   endfunction
   function automatic int tag_of(input logic [63:0] pc);
      return int'((pc / 64'(4 * ENTRIES)) % 64'(1 << TAG_W));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 1;
      end
      m_rv = 0; m_rpc = '0; m_bc = '0; m_mc = '0;
   endtask

   task automatic model_predict(input logic [63:0] pc, output bit tk, output logic [63:0] tg);
      int i = idx_of(pc);
      tk = m_valid[i] && m_tag[i] == tag_of(pc) && (m_jump[i] || m_cnt[i] >= 2);
      tg = tk ? m_tgt[i] : pc + 64'd4;
   endtask

   task automatic model_edge();
      bit acc, mis, hit;
      int i, t;
      logic [63:0] nxt;
      acc = bus.ex_valid && !m_rv;
      nxt = bus.ex_taken ? bus.ex_target : bus.ex_pc + 64'd4;
      mis = (bus.ex_pred_taken != bus.ex_taken) || (bus.ex_taken && bus.ex_pred_target != bus.ex_target);
      m_rv = acc && mis;
      if (!acc) return;
      m_bc = m_bc + 1;
      if (mis) begin
         m_mc  = m_mc + 1;
         m_rpc = nxt;
      end
      i = idx_of(bus.ex_pc);
      t = tag_of(bus.ex_pc);
      hit = m_valid[i] && m_tag[i] == t;
      if (hit) begin
         if (!bus.ex_is_jump) m_cnt[i] = bus.ex_taken ? (m_cnt[i] == 3 ? 3 : m_cnt[i] + 1)
                                                      : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
         if (bus.ex_taken) m_tgt[i] = bus.ex_target;
      end else if (bus.ex_taken) begin
         m_valid[i] = 1; m_tag[i] = t; m_jump[i] = bus.ex_is_jump; m_cnt[i] = 2; m_tgt[i] = bus.ex_target;
      end
   endtask

   task automatic drive(input vec_t v);
      bus.if_pc = v.if_pc; bus.ex_valid = v.ev; bus.ex_pc = v.ex_pc; bus.ex_is_jump = v.jmp;
      bus.ex_taken = v.tk; bus.ex_target = v.tgt; bus.ex_pred_taken = v.ptk; bus.ex_pred_target = v.ptgt;
   endtask

   task automatic pre_check();
      bit pt;
      logic [63:0] ptg;
      model_predict(bus.if_pc, pt, ptg);
      check("pred_taken", 64'(bus.pred_taken), 64'(pt));
      check("pred_target", bus.pred_target, ptg);
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      #1;
      check("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
      check("redirect_pc", bus.redirect_pc, m_rpc);
      check("branch_cnt", 64'(bus.branch_cnt), 64'(m_bc));
      check("mispred_cnt", 64'(bus.mispred_cnt), 64'(m_mc));
   endtask

   function automatic logic [63:0] pick_pc();
      return ($urandom_range(0, 1) ? 64'h8000_0000 : 64'h0) +
             64'($urandom_range(0, 2)) * 64'd16 + 64'($urandom_range(0, 3)) * 64'd4;
   endfunction
   function automatic logic [63:0] pick_tgt();
      return 64'h8000_1000 + 64'($urandom_range(0, 7)) * 64'd16;
   endfunction

   initial begin
      vec_t v;
      bit pt;
      logic [63:0] ptg;
      //          if_pc             ev ex_pc          j  t  tgt            pt ptgt           e_pt e_ptgt     e_rv e_rpc   bc mc
      tv[0]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 1, 64'h8000_0040, 0, 64'h8000_0014, 0, 64'h8000_0014, 1, 64'h8000_0040, 1, 1};
      tv[1]  = '{64'h8000_0010, 0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         1, 64'h8000_0040, 0, 64'h8000_0040, 1, 1};
      tv[2]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 0, 64'h8000_0040, 1, 64'h8000_0040, 1, 64'h8000_0040, 1, 64'h8000_0014, 2, 2};
      tv[3]  = '{64'h8000_0010, 0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         0, 64'h8000_0014, 0, 64'h8000_0014, 2, 2};
      tv[4]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 0, 64'h8000_0040, 0, 64'h8000_0014, 0, 64'h8000_0014, 0, 64'h8000_0014, 3, 2};
      tv[5]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 0, 64'h8000_0040, 0, 64'h8000_0014, 0, 64'h8000_0014, 0, 64'h8000_0014, 4, 2};
      tv[6]  = '{64'h8000_0010, 0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         0, 64'h8000_0014, 0, 64'h8000_0014, 4, 2};
      tv[7]  = '{64'h8000_0010, 1, 64'h8000_0104, 1, 1, 64'h8000_0200, 0, 64'h8000_0108, 0, 64'h8000_0014, 1, 64'h8000_0200, 5, 3};
      tv[8]  = '{64'h8000_0104, 1, 64'h8000_0108, 0, 1, 64'h8000_0300, 0, 64'h8000_010C, 1, 64'h8000_0200, 0, 64'h8000_0200, 5, 3};
      tv[9]  = '{64'h8000_0108, 0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         0, 64'h8000_010C, 0, 64'h8000_0200, 5, 3};
      tv[10] = '{64'h0,         1, 64'h0,         1, 1, 64'h1000,      0, 64'h4,         0, 64'h4,         1, 64'h1000,      6, 4};
      tv[11] = '{64'h0,         0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         1, 64'h1000,      0, 64'h1000,      6, 4};
      tv[12] = '{64'h10,        1, 64'h10,        1, 1, 64'h2000,      0, 64'h14,        0, 64'h14,        1, 64'h2000,      7, 5};
      tv[13] = '{64'h0,         0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         0, 64'h4,         0, 64'h2000,      7, 5};
      tv[14] = '{64'h10,        0, 64'h0,         0, 0, 64'h0,         0, 64'h0,         1, 64'h2000,      0, 64'h2000,      7, 5};
      tv[15] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 0, 64'h0,      0, 64'h0,         0, 64'h0,         0, 64'h2000,      7, 5};
      v = tv[1];
      v.if_pc = 64'h8000_0000;
      drive(v);
      #1 reset = 1'b1;
      #1;
      model_reset();
      check("rst_pred_taken", 64'(bus.pred_taken), 64'd0);
      check("rst_pred_target", bus.pred_target, 64'h8000_0004);
      check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
      check("rst_redirect_pc", bus.redirect_pc, 64'd0);
      check("rst_branch_cnt", 64'(bus.branch_cnt), 64'd0);
      check("rst_mispred_cnt", 64'(bus.mispred_cnt), 64'd0);
      #10 reset = 1'b0;
      edge_step();
      for (int k = 0; k < 16; k++) begin
         drive(tv[k]);
         #1;
         pre_check();
         check($sformatf("row%0d_pred_taken", k), 64'(bus.pred_taken), 64'(tv[k].e_pt));
         check($sformatf("row%0d_pred_target", k), bus.pred_target, tv[k].e_ptgt);
         edge_step();
         check($sformatf("row%0d_redirect_valid", k), 64'(bus.redirect_valid), 64'(tv[k].e_rv));
         check($sformatf("row%0d_redirect_pc", k), bus.redirect_pc, tv[k].e_rpc);
         check($sformatf("row%0d_branch_cnt", k), 64'(bus.branch_cnt), 64'(tv[k].e_bc));
         check($sformatf("row%0d_mispred_cnt", k), 64'(bus.mispred_cnt), 64'(tv[k].e_mc));
      end
      for (int n = 0; n < 400; n++) begin
         v.if_pc = pick_pc();
         v.ev    = $urandom_range(0, 9) < 7;
         v.ex_pc = pick_pc();
         v.jmp   = $urandom_range(0, 3) == 0;
         v.tk    = v.jmp || $urandom_range(0, 1) == 1;
         v.tgt   = pick_tgt();
         model_predict(v.ex_pc, pt, ptg);
         v.ptk  = pt;
         v.ptgt = ptg;
         if ($urandom_range(0, 3) == 0) begin
            v.ptk  = $urandom_range(0, 1) == 1;
            v.ptgt = pick_tgt();
         end
         drive(v);
         #1;
         pre_check();
         edge_step();
      end
      v = tv[1];
      v.if_pc = 64'h40;
      drive(v);
      #1;
      edge_step();
      v = '{64'h40, 1, 64'h40, 0, 1, 64'h80, 0, 64'h44, 0, 64'h0, 0, 64'h0, 0, 0};
      drive(v);
      #1;
      pre_check();
      edge_step();
      check("t6_redirect_set", 64'(bus.redirect_valid), 64'd1);
      reset = 1'b1;
      bus.ex_valid = 1'b0;
      #1;
      model_reset();
      check("t6_rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
      check("t6_rst_redirect_pc", bus.redirect_pc, 64'd0);
      check("t6_rst_branch_cnt", 64'(bus.branch_cnt), 64'd0);
      check("t6_rst_pred_taken", 64'(bus.pred_taken), 64'd0);
      check("t6_rst_pred_target", bus.pred_target, 64'h44);
      #3 reset = 1'b0;
      force dut.bcnt = 32'hFFFF_FFFF;
      #1 release dut.bcnt;
      m_bc = 32'hFFFF_FFFF;
      v = '{64'h40, 1, 64'h40, 0, 0, 64'h80, 0, 64'h44, 0, 64'h0, 0, 64'h0, 0, 0};
      drive(v);
      #1;
      pre_check();
      edge_step();
      check("t6_branch_cnt_wrap", 64'(bus.branch_cnt), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
